// File: rtl/texel_quad_arbiter_pkg.sv
// Shared constants and types for the texel-quad read arbiter.
package texel_quad_arbiter_pkg;

  localparam logic TEXEL_QUAD_REQ_TMU0 = 1'b0;
  localparam logic TEXEL_QUAD_REQ_TMU1 = 1'b1;

  // One stage of the in-flight read tracker: was a read issued, and for whom.
  typedef struct packed {
    logic valid;
    logic id;
  } tq_tag_t;

endpackage

// File: rtl/texel_quad_resp_fifo.sv
// First-word fall-through response FIFO holding returned texel quads.
module texel_quad_resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 128
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy tracking; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop_ok) rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Data storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/texel_quad_arbiter.sv
// Round-robin arbiter sharing one texel-quad memory read port between two TMUs.
module texel_quad_arbiter
  import texel_quad_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned PIXEL_WIDTH  = 32,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned RESP_DEPTH   = 4
) (
  input  logic                     aclk,
  input  logic                     reset,
  input  logic                     s0_valid,
  output logic                     s0_ready,
  input  logic [4*ADDR_WIDTH-1:0]  s0_addr,
  output logic                     m0_valid,
  input  logic                     m0_ready,
  output logic [4*PIXEL_WIDTH-1:0] m0_texels,
  input  logic                     s1_valid,
  output logic                     s1_ready,
  input  logic [4*ADDR_WIDTH-1:0]  s1_addr,
  output logic                     m1_valid,
  input  logic                     m1_ready,
  output logic [4*PIXEL_WIDTH-1:0] m1_texels,
  output logic                     mem_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr00,
  output logic [ADDR_WIDTH-1:0]    mem_addr01,
  output logic [ADDR_WIDTH-1:0]    mem_addr10,
  output logic [ADDR_WIDTH-1:0]    mem_addr11,
  input  logic [PIXEL_WIDTH-1:0]   mem_texel00,
  input  logic [PIXEL_WIDTH-1:0]   mem_texel01,
  input  logic [PIXEL_WIDTH-1:0]   mem_texel10,
  input  logic [PIXEL_WIDTH-1:0]   mem_texel11
);

  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

  tq_tag_t                  tag_q [READ_LATENCY];
  logic                     last_grant_q, last_grant_d;
  logic                     grant0, grant1, elig0, elig1;
  logic                     pop0, pop1, push0, push1;
  logic                     fifo0_empty, fifo1_empty;
  logic [CW-1:0]            fifo0_count, fifo1_count;
  logic [4*PIXEL_WIDTH-1:0] mem_quad;
  logic [4*ADDR_WIDTH-1:0]  sel_addr;
  int unsigned              inflight0, inflight1;

  // Count reads in flight per requester from the tag pipeline.
  always_comb begin
    inflight0 = 0;
    inflight1 = 0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      if (tag_q[i].valid) begin
        if (tag_q[i].id == TEXEL_QUAD_REQ_TMU1) inflight1 = inflight1 + 1;
        else                                     inflight0 = inflight0 + 1;
      end
    end
  end

  // Credit is free FIFO slots minus reads in flight; computed from occupancy
  // plus tags, which equals a counter decremented on grant and bumped on pop.
  assign elig0 = !reset && s0_valid && ((32'(fifo0_count) + inflight0) < RESP_DEPTH);
  assign elig1 = !reset && s1_valid && ((32'(fifo1_count) + inflight1) < RESP_DEPTH);

  // Round-robin grant: on a tie the requester not granted last wins.
  always_comb begin
    grant0 = elig0;
    grant1 = elig1;
    if (elig0 && elig1) begin
      grant0 = (last_grant_q == TEXEL_QUAD_REQ_TMU1);
      grant1 = (last_grant_q == TEXEL_QUAD_REQ_TMU0);
    end
    last_grant_d = last_grant_q;
    if (grant0) last_grant_d = TEXEL_QUAD_REQ_TMU0;
    if (grant1) last_grant_d = TEXEL_QUAD_REQ_TMU1;
  end

  assign s0_ready   = grant0;
  assign s1_ready   = grant1;
  assign mem_en     = grant0 | grant1;
  assign sel_addr   = grant1 ? s1_addr : s0_addr;
  assign mem_addr00 = sel_addr[0*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_addr01 = sel_addr[1*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_addr10 = sel_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_addr11 = sel_addr[3*ADDR_WIDTH +: ADDR_WIDTH];

  // Arbitration history and in-flight tag shift register.
  always_ff @(posedge aclk) begin
    if (reset) begin
      last_grant_q <= TEXEL_QUAD_REQ_TMU1;
      for (int unsigned i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      tag_q[0]     <= '{valid: mem_en, id: grant1};
      for (int unsigned i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign mem_quad = {mem_texel11, mem_texel10, mem_texel01, mem_texel00};
  assign push0 = tag_q[READ_LATENCY-1].valid && (tag_q[READ_LATENCY-1].id == TEXEL_QUAD_REQ_TMU0);
  assign push1 = tag_q[READ_LATENCY-1].valid && (tag_q[READ_LATENCY-1].id == TEXEL_QUAD_REQ_TMU1);
  assign m0_valid = !reset && !fifo0_empty;
  assign m1_valid = !reset && !fifo1_empty;
  assign pop0 = m0_valid && m0_ready;
  assign pop1 = m1_valid && m1_ready;

  texel_quad_resp_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(4*PIXEL_WIDTH)) u_fifo0 (
    .clk_i(aclk), .rst_i(reset), .push_i(push0), .wdata_i(mem_quad),
    .pop_i(pop0), .rdata_o(m0_texels), .empty_o(fifo0_empty), .count_o(fifo0_count)
  );

  texel_quad_resp_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(4*PIXEL_WIDTH)) u_fifo1 (
    .clk_i(aclk), .rst_i(reset), .push_i(push1), .wdata_i(mem_quad),
    .pop_i(pop1), .rdata_o(m1_texels), .empty_o(fifo1_empty), .count_o(fifo1_count)
  );

endmodule

// File: tb/tb_texel_quad_arbiter.sv
// Self-checking bench: randomized and directed traffic against a queue-based model.
module tb_texel_quad_arbiter;

  localparam int AW = 17;
  localparam int PW = 32;
  localparam int RL = 2;
  localparam int RD = 4;

  logic            aclk, reset;
  logic            s0_valid, s0_ready, m0_valid, m0_ready;
  logic            s1_valid, s1_ready, m1_valid, m1_ready;
  logic [4*AW-1:0] s0_addr, s1_addr;
  logic [4*PW-1:0] m0_texels, m1_texels;
  logic            mem_en;
  logic [AW-1:0]   mem_addr00, mem_addr01, mem_addr10, mem_addr11;
  logic [PW-1:0]   mem_texel00, mem_texel01, mem_texel10, mem_texel11;

  texel_quad_arbiter #(
    .ADDR_WIDTH(AW), .PIXEL_WIDTH(PW), .READ_LATENCY(RL), .RESP_DEPTH(RD)
  ) dut (
    .aclk(aclk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_texels(m0_texels),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_texels(m1_texels),
    .mem_en(mem_en),
    .mem_addr00(mem_addr00), .mem_addr01(mem_addr01),
    .mem_addr10(mem_addr10), .mem_addr11(mem_addr11),
    .mem_texel00(mem_texel00), .mem_texel01(mem_texel01),
    .mem_texel10(mem_texel10), .mem_texel11(mem_texel11)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [4*AW-1:0] addr;
    int unsigned     rdy;
  } ent_t;

  ent_t            q0[$], q1[$];
  int unsigned     ec;
  bit              lg;
  int              ncmp, nfail;
  logic [4*AW-1:0] h_addr [16];
  bit              h_en   [16];

  function automatic logic [PW-1:0] texel_of(input logic [AW-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return (a32 * 32'h9E3779B1) ^ 32'hAABBCCDD;
  endfunction

  function automatic logic [4*PW-1:0] quad_of(input logic [4*AW-1:0] a);
    return {texel_of(a[3*AW +: AW]), texel_of(a[2*AW +: AW]),
            texel_of(a[1*AW +: AW]), texel_of(a[0*AW +: AW])};
  endfunction

  function automatic logic [4*AW-1:0] rnd_addr();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[4*AW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs before the edge, advance the model, drive memory data.
  task automatic cycle();
    bit e0, e1, g0, g1, ev0, ev1, p0, p1, men;
    logic [4*AW-1:0] maddr, a0, a1;
    int unsigned idx;
    logic [4*PW-1:0] md;
    #1;
    e0 = !reset && s0_valid && (q0.size() < RD);
    e1 = !reset && s1_valid && (q1.size() < RD);
    if (e0 && e1) begin g0 = lg; g1 = !lg; end
    else begin g0 = e0; g1 = e1; end
    ev0 = !reset && (q0.size() > 0) && (ec >= q0[0].rdy);
    ev1 = !reset && (q1.size() > 0) && (ec >= q1[0].rdy);
    chk("s0_ready", s0_ready, g0);
    chk("s1_ready", s1_ready, g1);
    chk("mem_en",   mem_en,   g0 | g1);
    chk("m0_valid", m0_valid, ev0);
    chk("m1_valid", m1_valid, ev1);
    maddr = {mem_addr11, mem_addr10, mem_addr01, mem_addr00};
    if (g0 | g1) chk("mem_addr", maddr, g1 ? s1_addr : s0_addr);
    if (ev0) chk("m0_texels", m0_texels, quad_of(q0[0].addr));
    if (ev1) chk("m1_texels", m1_texels, quad_of(q1[0].addr));
    p0 = ev0 && m0_ready;
    p1 = ev1 && m1_ready;
    men = mem_en;
    a0 = s0_addr;
    a1 = s1_addr;
    @(posedge aclk);
    ec++;
    h_en[ec % 16]   = men;
    h_addr[ec % 16] = maddr;
    if (reset) begin
      q0.delete();
      q1.delete();
      lg = 1'b1;
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (g0) begin q0.push_back('{addr: a0, rdy: ec + RL}); lg = 1'b0; end
      if (g1) begin q1.push_back('{addr: a1, rdy: ec + RL}); lg = 1'b1; end
    end
    #1;
    idx = (ec + 1 - RL) % 16;
    if (ec + 1 >= RL && h_en[idx]) md = quad_of(h_addr[idx]);
    else md = {$urandom, $urandom, $urandom, $urandom};
    {mem_texel11, mem_texel10, mem_texel01, mem_texel00} = md;
    @(negedge aclk);
  endtask

  task automatic drive(input bit v0, input bit v1, input bit r0, input bit r1);
    s0_valid = v0; s1_valid = v1; m0_ready = r0; m1_ready = r1;
    s0_addr = rnd_addr();
    s1_addr = rnd_addr();
  endtask

  initial begin
    ncmp = 0; nfail = 0; ec = 0; lg = 1'b1;
    for (int i = 0; i < 16; i++) begin h_en[i] = 1'b0; h_addr[i] = '0; end
    {mem_texel11, mem_texel10, mem_texel01, mem_texel00} = '0;
    reset = 1'b1;
    drive(1, 1, 1, 1);
    @(negedge aclk);
    // Reset state: valid requests must not be granted while reset is high.
    cycle();
    cycle();
    reset = 1'b0;
    drive(0, 0, 1, 1);
    cycle();

    // Single read on TMU0 followed by idle cycles to watch the response arrive.
    drive(1, 0, 1, 1);
    s0_addr = {17'h00111, 17'h00110, 17'h00011, 17'h00010};
    cycle();
    drive(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cycle();

    // Round-robin with both requesters continuously valid.
    for (int i = 0; i < 10; i++) begin drive(1, 1, 1, 1); cycle(); end
    for (int i = 0; i < 5; i++) begin drive(0, 0, 1, 1); cycle(); end

    // Backpressure on TMU0 while TMU1 keeps streaming, then release.
    for (int i = 0; i < 12; i++) begin drive(1, 1, 0, 1); cycle(); end
    for (int i = 0; i < 8; i++)  begin drive(1, 0, 1, 1); cycle(); end
    for (int i = 0; i < 5; i++)  begin drive(0, 0, 1, 1); cycle(); end

    // Grant and pop colliding near the credit limit.
    for (int i = 0; i < 24; i++) begin drive(1, 0, i[0], 1); cycle(); end
    for (int i = 0; i < 5; i++)  begin drive(0, 0, 1, 1); cycle(); end

    // Reset with reads in flight and entries queued; stale data must be dropped.
    for (int i = 0; i < 5; i++) begin drive(1, 1, 0, 0); cycle(); end
    reset = 1'b1;
    drive(1, 1, 1, 1);
    cycle();
    reset = 1'b0;
    drive(1, 1, 0, 0);
    cycle();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle();
    for (int i = 0; i < 8; i++) begin drive(0, 0, 1, 1); cycle(); end

    // Random stress with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0);
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin drive(0, 0, 1, 1); cycle(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
